// File: rtl/pipe_defs_pkg.sv
// pipe_defs: shared MEM-stage definitions (datapath widths, FSM encodings, helpers).
`default_nettype none

package pipe_defs;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: wait-cycle counter with synchronous clear, enable and terminal-count flag.
`default_nettype none

module mem_wait_timer #(
  parameter int CNT_W    = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic             clock,
  input  logic             reset_0,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(MAX_WAIT - 1);

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign term = (count == TERM_VAL);

endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller running loads/stores on a req/ack data-memory bus
// with pipeline stall, watchdog abort, misalignment rejection and ME->WB registers.
`default_nettype none

module mem_stage_ctrl
  import pipe_defs::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clock,
  input  logic             reset_0,
  input  logic [XLEN-1:0]  ans_me,
  input  logic [XLEN-1:0]  b_me,
  input  logic [REG_W-1:0] rw_me,
  input  logic             wreg_me,
  input  logic             m2reg_me,
  input  logic             wmem_me,
  output logic             dm_req,
  output logic             dm_we,
  output logic [XLEN-1:0]  dm_addr,
  output logic [XLEN-1:0]  dm_wdata,
  input  logic             dm_ack,
  input  logic [XLEN-1:0]  dm_rdata,
  output logic             stall_me,
  output logic [XLEN-1:0]  ans_wb,
  output logic [XLEN-1:0]  mo_wb,
  output logic [REG_W-1:0] rw_wb,
  output logic             wreg_wb,
  output logic             m2reg_wb,
  output logic             bus_err,
  output logic [XLEN-1:0]  err_addr
);

  logic [0:0]       state;
  logic             mop;
  logic             aligned;
  logic             in_req;
  logic             ack_now;
  logic             start_req;
  logic             wait_more;
  logic             err_now;
  logic             wb_writes;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_term;

  assign mop       = m2reg_me | wmem_me;
  assign aligned   = is_word_aligned(ans_me);
  assign in_req    = (state == ST_REQ);
  assign ack_now   = in_req & dm_ack;
  assign start_req = ~in_req & mop & aligned;
  assign wait_more = in_req & ~dm_ack & ~wait_term;
  assign err_now   = (in_req & ~dm_ack & wait_term) | (~in_req & mop & ~aligned);
  assign wb_writes = wreg_me & (rw_me != '0);

  // Gated by reset so the stall output is low while reset is held.
  assign stall_me = reset_0 & (start_req | wait_more);

  mem_wait_timer #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clock   (clock),
    .reset_0 (reset_0),
    .clear   (start_req),
    .enable  (wait_more),
    .count   (wait_cnt),
    .term    (wait_term)
  );

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      state    <= ST_IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      ans_wb   <= '0;
      mo_wb    <= '0;
      rw_wb    <= '0;
      wreg_wb  <= 1'b0;
      m2reg_wb <= 1'b0;
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            dm_req   <= 1'b1;
            dm_we    <= wmem_me;
            dm_addr  <= ans_me;
            dm_wdata <= b_me;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dm_ack || wait_term) begin
            dm_req <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A store wins when both load and store flags are set.
      if (ack_now) begin
        ans_wb <= ans_me;
        rw_wb  <= rw_me;
        if (wmem_me) begin
          wreg_wb  <= 1'b0;
          m2reg_wb <= 1'b0;
        end else begin
          mo_wb    <= dm_rdata;
          m2reg_wb <= 1'b1;
          wreg_wb  <= wb_writes;
        end
      end else if (!in_req && !mop) begin
        ans_wb   <= ans_me;
        rw_wb    <= rw_me;
        m2reg_wb <= 1'b0;
        wreg_wb  <= wb_writes;
      end else begin
        wreg_wb  <= 1'b0;
        m2reg_wb <= 1'b0;
      end

      if (err_now && !bus_err) begin
        bus_err  <= 1'b1;
        err_addr <= ans_me;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: table-driven, scoreboarded bench for mem_stage_ctrl.
`default_nettype none

module tb_mem_stage_ctrl;

  localparam int MAX_WAIT = 15;

  logic        clock = 1'b0;
  logic        reset_0;
  logic [31:0] ans_me, b_me, dm_rdata;
  logic [4:0]  rw_me;
  logic        wreg_me, m2reg_me, wmem_me, dm_ack;
  logic        dm_req, dm_we, stall_me, wreg_wb, m2reg_wb, bus_err;
  logic [31:0] dm_addr, dm_wdata, ans_wb, mo_wb, err_addr;
  logic [4:0]  rw_wb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ans;
    logic [31:0] b;
    logic [4:0]  rw;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    int          ack_wait;
    logic [31:0] rdata;
    logic [31:0] e_ans;
    logic [4:0]  e_rw;
    logic        e_wreg;
    logic        e_m2reg;
    logic [31:0] e_mo;
    logic        e_err;
    logic [31:0] e_eaddr;
  } vec_t;

  vec_t vecs[9];
  vec_t sb_q[$];

  mem_stage_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clock    (clock),
    .reset_0  (reset_0),
    .ans_me   (ans_me),
    .b_me     (b_me),
    .rw_me    (rw_me),
    .wreg_me  (wreg_me),
    .m2reg_me (m2reg_me),
    .wmem_me  (wmem_me),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_ack   (dm_ack),
    .dm_rdata (dm_rdata),
    .stall_me (stall_me),
    .ans_wb   (ans_wb),
    .mo_wb    (mo_wb),
    .rw_wb    (rw_wb),
    .wreg_wb  (wreg_wb),
    .m2reg_wb (m2reg_wb),
    .bus_err  (bus_err),
    .err_addr (err_addr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ans_me = '0; b_me = '0; rw_me = '0;
    wreg_me = 1'b0; m2reg_me = 1'b0; wmem_me = 1'b0;
    dm_ack = 1'b0; dm_rdata = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the WB result was compared.
  task automatic issue_op(input vec_t v);
    vec_t e;
    bit   done;
    bit   exp_stall;
    ans_me = v.ans; b_me = v.b; rw_me = v.rw;
    wreg_me = v.wreg; m2reg_me = v.m2reg; wmem_me = v.wmem;
    sb_q.push_back(v);
    #1;
    if ((v.m2reg || v.wmem) && v.ans[1:0] == 2'b00) begin
      chk("stall_idle", {31'd0, stall_me}, 32'd1);
      @(posedge clock); #1;
      chk("dm_addr", dm_addr, v.ans);
      chk("dm_we", {31'd0, dm_we}, {31'd0, v.wmem});
      if (v.wmem) chk("dm_wdata", dm_wdata, v.b);
      done = 1'b0;
      for (int i = 0; i < MAX_WAIT && !done; i++) begin
        chk("dm_req_busy", {31'd0, dm_req}, 32'd1);
        chk("wreg_wb_bubble", {31'd0, wreg_wb}, 32'd0);
        if (i == v.ack_wait) begin
          dm_ack = 1'b1;
          dm_rdata = v.rdata;
        end
        #1;
        exp_stall = (i != v.ack_wait) && (i != MAX_WAIT - 1);
        chk("stall_req", {31'd0, stall_me}, {31'd0, exp_stall});
        @(posedge clock); #1;
        dm_ack = 1'b0;
        dm_rdata = '0;
        if (!exp_stall) done = 1'b1;
      end
      if (!done) begin
        errors++;
        $display("FAIL req_bound actual=busy expected=done");
      end
    end else begin
      chk("stall_nomem", {31'd0, stall_me}, 32'd0);
      // A stray ack while idle must be ignored.
      dm_ack = 1'b1;
      dm_rdata = 32'hFFFF_FFFF;
      @(posedge clock); #1;
      dm_ack = 1'b0;
      dm_rdata = '0;
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard actual=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      chk("ans_wb", ans_wb, e.e_ans);
      chk("rw_wb", {27'd0, rw_wb}, {27'd0, e.e_rw});
      chk("wreg_wb", {31'd0, wreg_wb}, {31'd0, e.e_wreg});
      chk("m2reg_wb", {31'd0, m2reg_wb}, {31'd0, e.e_m2reg});
      chk("mo_wb", mo_wb, e.e_mo);
      chk("bus_err", {31'd0, bus_err}, {31'd0, e.e_err});
      chk("err_addr", err_addr, e.e_eaddr);
      chk("dm_req_done", {31'd0, dm_req}, 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    // ans, b, rw, wreg, m2reg, wmem, ack_wait, rdata | ans_wb, rw_wb, wreg_wb, m2reg_wb, mo_wb, bus_err, err_addr
    vecs[0] = '{32'h10,  32'h0,        5'd5,  1'b1, 1'b0, 1'b0, -1, 32'h0,
                32'h10,  5'd5,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1] = '{32'h44,  32'h0,        5'd0,  1'b1, 1'b0, 1'b0, -1, 32'h0,
                32'h44,  5'd0,  1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2] = '{32'h100, 32'h0,        5'd8,  1'b1, 1'b1, 1'b0,  2, 32'hDEADBEEF,
                32'h100, 5'd8,  1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3] = '{32'h20,  32'h12345678, 5'd3,  1'b0, 1'b0, 1'b1,  0, 32'h0,
                32'h20,  5'd3,  1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4] = '{32'h24,  32'hCAFEF00D, 5'd4,  1'b1, 1'b1, 1'b1,  0, 32'hAAAA5555,
                32'h24,  5'd4,  1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[5] = '{32'h200, 32'h0,        5'd9,  1'b1, 1'b1, 1'b0, -1, 32'h0,
                32'h24,  5'd4,  1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h200};
    vecs[6] = '{32'h102, 32'h0,        5'd7,  1'b1, 1'b1, 1'b0, -1, 32'h0,
                32'h24,  5'd4,  1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h200};
    vecs[7] = '{32'h55,  32'h0,        5'd31, 1'b1, 1'b0, 1'b0, -1, 32'h0,
                32'h55,  5'd31, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 32'h200};
    vecs[8] = '{32'h300, 32'h0,        5'd2,  1'b0, 1'b1, 1'b0,  1, 32'h0BADF00D,
                32'h300, 5'd2,  1'b0, 1'b1, 32'h0BADF00D, 1'b1, 32'h200};

    reset_0 = 1'b0;
    clear_inputs();
    @(posedge clock); @(posedge clock); #1;
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_me}, 32'd0);
    chk("rst_ans_wb", ans_wb, 32'd0);
    chk("rst_wreg_wb", {31'd0, wreg_wb}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    reset_0 = 1'b1;
    @(posedge clock); #1;

    for (int k = 0; k < 9; k++) issue_op(vecs[k]);

    // Reset asserted during the third REQ cycle of an unanswered load.
    ans_me = 32'h400; rw_me = 5'd6; wreg_me = 1'b1; m2reg_me = 1'b1; wmem_me = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("pre_rst_req", {31'd0, dm_req}, 32'd1);
    reset_0 = 1'b0;
    #1;
    chk("arst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("arst_stall", {31'd0, stall_me}, 32'd0);
    chk("arst_ans_wb", ans_wb, 32'd0);
    chk("arst_rw_wb", {27'd0, rw_wb}, 32'd0);
    chk("arst_mo_wb", mo_wb, 32'd0);
    chk("arst_m2reg_wb", {31'd0, m2reg_wb}, 32'd0);
    chk("arst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("arst_err_addr", err_addr, 32'd0);
    @(posedge clock); #1;
    reset_0 = 1'b1;
    clear_inputs();
    @(posedge clock); #1;

    v = '{32'h104, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 0, 32'h13579BDF,
          32'h104, 5'd10, 1'b1, 1'b1, 32'h13579BDF, 1'b0, 32'h0};
    issue_op(v);
    v = '{32'h102, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, -1, 32'h0,
          32'h104, 5'd10, 1'b0, 1'b0, 32'h13579BDF, 1'b1, 32'h102};
    issue_op(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller that consumes the EX->ME pipeline register outputs (ans_me, b_me, rw_me, wreg_me, m2reg_me, wmem_me).
- Runs load/store transactions on a variable-latency data-memory req/ack bus and holds upstream stages via stall_me while a transaction is in flight.
- Registers results into the ME->WB boundary.
- Watchdog aborts hung transactions; misaligned accesses are rejected.

Parameters:
- MAX_WAIT, 15: REQ cycles without dm_ack before abort; must be less than 2^CNT_W.
- CNT_W, 4: wait-counter width.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset_0  in  1  asynchronous active-low reset.
- ans_me  in  32  ALU result / memory byte address.
- b_me  in  32  store data.
- rw_me  in  5  destination register.
- wreg_me  in  1  register-write enable.
- m2reg_me  in  1  load.
- wmem_me  in  1  store.
- dm_req  out  1  memory request, registered.
- dm_we  out  1  1 = write, registered.
- dm_addr  out  32  word-aligned address, registered.
- dm_wdata  out  32  store data, registered.
- dm_ack  in  1  one-cycle completion strobe.
- dm_rdata  in  32  load data, valid only with dm_ack.
- stall_me  out  1  hold EX->ME and earlier registers.
- ans_wb  out  32  registered ALU result.
- mo_wb  out  32  registered load data.
- rw_wb  out  5  registered destination.
- wreg_wb  out  1  registered write enable.
- m2reg_wb  out  1  registered load select.
- bus_err  out  1  sticky error flag.
- err_addr  out  32  address of first error.

Behaviour:
- Reset (reset_0 = 0, asynchronous): every output is 0, including dm_req, stall_me, the WB outputs, bus_err and err_addr. State is IDLE and the wait counter is 0. A transaction in flight is dropped and no WB write occurs.
- States: IDLE, REQ.
- Memory op: mop = m2reg_me | wmem_me.
  - If wmem_me and m2reg_me are both 1, treat it as a store and suppress writeback.
- Misaligned op (IDLE, mop = 1, ans_me[1:0] != 0):
  - No request is issued and stall_me = 0.
  - Next edge: WB outputs load a bubble (wreg_wb = 0, m2reg_wb = 0).
  - If bus_err = 0: bus_err <= 1 and err_addr <= ans_me.
- IDLE, mop = 0:
  - stall_me = 0.
  - Next edge: ans_wb <= ans_me, rw_wb <= rw_me, m2reg_wb <= 0, wreg_wb <= wreg_me & (rw_me != 0).
- IDLE, mop = 1, aligned:
  - stall_me = 1 combinationally.
  - Next edge: dm_req <= 1, dm_we <= wmem_me, dm_addr <= ans_me, dm_wdata <= b_me, counter <= 0, state <= REQ. WB gets a bubble.
- REQ:
  - dm_req = 1, and EX->ME inputs are stable because of the stall.
  - If dm_ack = 1: stall_me = 0 in that same cycle (combinational from dm_ack). Next edge:
    - dm_req <= 0 and state <= IDLE.
    - For a load: mo_wb <= dm_rdata, m2reg_wb <= 1, wreg_wb <= wreg_me & (rw_me != 0).
    - For a store: wreg_wb <= 0.
    - ans_wb <= ans_me and rw_wb <= rw_me.
  - Else if counter == MAX_WAIT - 1 (abort):
    - stall_me = 0 this cycle.
    - Next edge: dm_req <= 0, state <= IDLE, WB bubble, bus_err / err_addr update as in the misaligned case.
  - Else: stall_me = 1, counter increments, WB bubble.
- Transaction latency: best case 2 cycles (ack in the first REQ cycle).
- Abort timing: a transaction with no ack is aborted after exactly MAX_WAIT REQ cycles.
- dm_ack outside REQ is ignored. dm_rdata is sampled only on the dm_ack cycle.
- bus_err clears only on reset. err_addr holds the first error address.
- Back-to-back memory ops: after completion, state returns to IDLE. The following op then needs its own IDLE->REQ cycle, so there is no zero-bubble chaining.

Decomposition:
- Shared package pipe_defs: state encodings (ST_IDLE, ST_REQ), XLEN = 32, REG_W = 5.
- One natural sub-module, mem_wait_timer: clear / enable / terminal-count counter, width CNT_W.

Test Plan:
- ALU pass-through: ans_me = 0x00000010, rw_me = 5, wreg_me = 1, mop = 0 -> next edge ans_wb = 0x10, rw_wb = 5, wreg_wb = 1, stall_me never 1, dm_req stays 0.
- Load, ack on third REQ cycle: ans_me = 0x100, m2reg_me = 1, rw_me = 8, dm_rdata = 0xDEADBEEF -> stall_me high 3 cycles, dm_addr = 0x100, dm_we = 0, then mo_wb = 0xDEADBEEF, m2reg_wb = 1, wreg_wb = 1, rw_wb = 8. Bubbles (wreg_wb = 0) during stall.
- Store with immediate ack: ans_me = 0x20, b_me = 0x12345678, wmem_me = 1 -> dm_we = 1, dm_wdata = 0x12345678, one request cycle, wreg_wb = 0, stall_me high exactly 1 cycle.
- Timeout: load, dm_ack held 0 -> dm_req high exactly 15 cycles then drops, bus_err = 1, err_addr = ans_me, wreg_wb = 0. A second error leaves err_addr unchanged.
- Misaligned plus $0 destination: ans_me = 0x102, m2reg_me = 1 -> no dm_req, bus_err = 1, err_addr = 0x102. Separately, an ALU op with rw_me = 0, wreg_me = 1 -> wreg_wb = 0.
- Reset mid-REQ: drop reset_0 during wait cycle 2 -> dm_req and stall_me go 0 immediately (asynchronous), all WB outputs 0. After release, a new load completes normally.
